// File: rtl/int_operand_collector_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_operand_collector_if : dispatcher / register-file / ALU bus      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface int_operand_collector_if #(
  parameter int DW  = 32,
  parameter int RAW = 5
);
  logic           instr_valid;
  logic           instr_ready;
  logic [3:0]     instr_op;
  logic [RAW-1:0] instr_rd;
  logic [RAW-1:0] instr_rs1;
  logic [RAW-1:0] instr_rs2;
  logic [RAW-1:0] instr_rs3;
  logic           rf_rd_en;
  logic [RAW-1:0] rf_rd_addr;
  logic [DW-1:0]  rf_rd_data;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_c;
  logic [3:0]     alu_op;
  logic [DW-1:0]  alu_y;
  logic           rf_wr_en;
  logic [RAW-1:0] rf_wr_addr;
  logic [DW-1:0]  rf_wr_data;
  logic           busy;

  modport master (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_rs3,
    input  rf_rd_data, alu_y,
    output instr_ready, rf_rd_en, rf_rd_addr, alu_a, alu_b, alu_c, alu_op,
    output rf_wr_en, rf_wr_addr, rf_wr_data, busy
  );

  modport slave (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_rs3,
    output rf_rd_data, alu_y,
    input  instr_ready, rf_rd_en, rf_rd_addr, alu_a, alu_b, alu_c, alu_op,
    input  rf_wr_en, rf_wr_addr, rf_wr_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/int_operand_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_operand_collector : fetches operands over one RF read port,      |
// | drives the integer ALU and writes the result back. Rev 1.0           |
// +----------------------------------------------------------------------+
module int_operand_collector #(
  parameter int DW    = 32,
  parameter int NREGS = 32,
  parameter int RAW   = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  int_operand_collector_if.master bus
);

  localparam logic [3:0] c_op_mad = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RS1  = 3'd1,
    S_RS2  = 3'd2,
    S_RS3  = 3'd3,
    S_EXEC = 3'd4,
    S_WB   = 3'd5
  } state_t;

  if (RAW != $clog2(NREGS)) begin : g_raw_check
    $error("RAW must equal clog2(NREGS)");
  end

  state_t         r_state;
  state_t         w_state_next;
  logic           w_rd_en;
  logic           w_is_mad;
  logic [DW-1:0]  w_opc;

  logic [3:0]     r_op;
  logic [RAW-1:0] r_rd;
  logic [RAW-1:0] r_rs2;
  logic [RAW-1:0] r_rs3;
  logic [RAW-1:0] r_rd_addr;
  logic [DW-1:0]  r_opa;
  logic [DW-1:0]  r_alu_a;
  logic [DW-1:0]  r_alu_b;
  logic [DW-1:0]  r_alu_c;
  logic [3:0]     r_alu_op;
  logic [DW-1:0]  r_result;
  logic [RAW-1:0] r_wr_addr;

  assign w_is_mad = (r_op == c_op_mad);
  assign w_opc    = w_is_mad ? bus.rf_rd_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.instr_valid) w_state_next = S_RS1;
      S_RS1: begin
        w_rd_en      = 1'b1;
        w_state_next = S_RS2;
      end
      S_RS2: begin
        w_rd_en      = 1'b1;
        w_state_next = S_RS3;
      end
      S_RS3: begin
        w_rd_en      = w_is_mad;
        w_state_next = S_EXEC;
      end
      S_EXEC:  w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The read address is staged one edge ahead so it is valid throughout the strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_rs2     <= '0;
      r_rs3     <= '0;
      r_rd_addr <= '0;
      r_opa     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_c   <= '0;
      r_alu_op  <= '0;
      r_result  <= '0;
      r_wr_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_op      <= bus.instr_op;
            r_rd      <= bus.instr_rd;
            r_rs2     <= bus.instr_rs2;
            r_rs3     <= bus.instr_rs3;
            r_rd_addr <= bus.instr_rs1;
          end
        end
        S_RS1: r_rd_addr <= r_rs2;
        S_RS2: begin
          r_opa <= bus.rf_rd_data;
          if (w_is_mad) r_rd_addr <= r_rs3;
        end
        S_RS3: begin
          r_alu_a  <= r_opa;
          r_alu_b  <= bus.rf_rd_data;
          r_alu_op <= r_op;
        end
        S_EXEC: begin
          r_alu_c   <= w_opc;
          r_result  <= bus.alu_y;
          r_wr_addr <= r_rd;
        end
        default: ;
      endcase
    end
  end

  // Operand C only arrives from the read port during EXEC, so it is passed through
  // in that cycle and held from its register afterwards.
  assign bus.alu_c       = (r_state == S_EXEC) ? w_opc : r_alu_c;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.rf_rd_en    = w_rd_en;
  assign bus.rf_rd_addr  = r_rd_addr;
  assign bus.rf_wr_en    = (r_state == S_WB);
  assign bus.rf_wr_addr  = r_wr_addr;
  assign bus.rf_wr_data  = r_result;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.instr_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire
